// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg
//   Shared types and helpers for the packet framer.
//   - state_t : framer FSM states (IDLE, PAYLOAD, CSUM)
//   - mk_hdr  : builds a header word as {seq, len}. The caller truncates
//               the result to the data width.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2
    } state_t;

    // Places the sequence number above a len_w-bit length field.
    // A 64-bit container keeps this independent of the instance widths.
    function automatic logic [63:0] mk_hdr(input logic [63:0] seq,
                                           input logic [63:0] len,
                                           input int unsigned len_w);
        return (seq << len_w) | len;
    endfunction

endpackage

// File: rtl/fifo_pkt_framer_out_reg.sv
// pkt_out_reg
//   Single output register slice for the framer. It holds data, sop, eop
//   and valid, and reports whether a new word may be loaded this cycle.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   load       in   capture d/sop/eop this edge; legal only when slot_free
//   d          in   word to load
//   sop, eop   in   flags to load
//   rdy        in   downstream ready
//   q          out  registered word
//   q_sop      out  registered sop flag
//   q_eop      out  registered eop flag
//   q_val      out  registered valid
//   slot_free  out  register is empty or drains this edge
module pkt_out_reg #(
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DataWidth-1:0] d,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 rdy,
    output logic [DataWidth-1:0] q,
    output logic                 q_sop,
    output logic                 q_eop,
    output logic                 q_val,
    output logic                 slot_free
);

    assign slot_free = !q_val || rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            q_sop <= 1'b0;
            q_eop <= 1'b0;
            q_val <= 1'b0;
        end else if (load) begin
            q     <= d;
            q_sop <= sop;
            q_eop <= eop;
            q_val <= 1'b1;
        end else if (slot_free) begin
            // The word drained and nothing replaced it. The fields keep
            // their values; only valid drops.
            q_val <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_pkt_framer.sv
// fifo_pkt_framer
//   Consumes the FIFO valid/ready word stream and frames it into packets:
//   a header {seq, PktLen}, PktLen payload words, and a checksum word. The
//   checksum makes the sum of all packet words zero mod 2^DataWidth.
// Ports
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   din_i       in   payload word from FIFO
//   din_val_i   in   FIFO word valid
//   din_rdy_o   out  framer accepts the word (PAYLOAD state with output slot free)
//   dout_o      out  packet word
//   dout_sop_o  out  header flag
//   dout_eop_o  out  checksum flag
//   dout_val_o  out  output valid
//   dout_rdy_i  in   downstream ready
module fifo_pkt_framer
    import fifo_pkt_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int PktLen    = 4,
    parameter int SeqWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] din_i,
    input  logic                 din_val_i,
    output logic                 din_rdy_o,
    output logic [DataWidth-1:0] dout_o,
    output logic                 dout_sop_o,
    output logic                 dout_eop_o,
    output logic                 dout_val_o,
    input  logic                 dout_rdy_i
);

    localparam int CntW = $clog2(PktLen + 1);
    localparam int LenW = DataWidth - SeqWidth;
    localparam logic [CntW-1:0] CntLast = CntW'(PktLen - 1);

    state_t                state;
    logic [CntW-1:0]       cnt;
    logic [SeqWidth-1:0]   seq;
    logic [DataWidth-1:0]  acc;

    logic                  slot_free;
    logic                  in_xfer;
    logic [DataWidth-1:0]  hdr;
    logic [DataWidth-1:0]  csum;

    logic                  ld;
    logic [DataWidth-1:0]  ld_data;
    logic                  ld_sop;
    logic                  ld_eop;

    assign hdr       = DataWidth'(mk_hdr(64'(seq), 64'(PktLen), LenW));
    assign csum      = '0 - acc;
    assign din_rdy_o = (state == PAYLOAD) && slot_free;
    assign in_xfer   = din_val_i && din_rdy_o;

    // Select what, if anything, goes into the output register this cycle.
    always_comb begin
        ld      = 1'b0;
        ld_data = '0;
        ld_sop  = 1'b0;
        ld_eop  = 1'b0;
        case (state)
            IDLE: begin
                // The header is emitted only once a word is waiting, but that
                // word is consumed later, in PAYLOAD.
                if (din_val_i && slot_free) begin
                    ld      = 1'b1;
                    ld_data = hdr;
                    ld_sop  = 1'b1;
                end
            end
            PAYLOAD: begin
                if (in_xfer) begin
                    ld      = 1'b1;
                    ld_data = din_i;
                end
            end
            CSUM: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_data = csum;
                    ld_eop  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            seq   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_val_i && slot_free) begin
                        acc   <= hdr;
                        cnt   <= '0;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_xfer) begin
                        acc <= acc + din_i;
                        cnt <= cnt + CntW'(1);
                        if (cnt == CntLast) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (slot_free) begin
                        seq   <= seq + SeqWidth'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pkt_out_reg #(.DataWidth(DataWidth)) u_out (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (ld),
        .d         (ld_data),
        .sop       (ld_sop),
        .eop       (ld_eop),
        .rdy       (dout_rdy_i),
        .q         (dout_o),
        .q_sop     (dout_sop_o),
        .q_eop     (dout_eop_o),
        .q_val     (dout_val_o),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// tb_fifo_pkt_framer
//   Directed vector table followed by a 256-packet sequence-wrap run.
module tb_fifo_pkt_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_val;
    logic        din_rdy;
    logic [15:0] dout;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_val;
    logic        dout_rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_pkt_framer #(.DataWidth(16), .PktLen(4), .SeqWidth(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .din_i      (din),
        .din_val_i  (din_val),
        .din_rdy_o  (din_rdy),
        .dout_o     (dout),
        .dout_sop_o (dout_sop),
        .dout_eop_o (dout_eop),
        .dout_val_o (dout_val),
        .dout_rdy_i (dout_rdy)
    );

    // One row per clock cycle. e_rdy is din_rdy_o before the edge. The
    // remaining e_* fields are the registered outputs after the edge. The
    // data and flags are compared only when chk_dat is set.
    typedef struct {
        logic        rst;
        logic        val;
        logic [15:0] din;
        logic        rdy;
        logic        e_rdy;
        logic [15:0] e_dout;
        logic        e_sop;
        logic        e_eop;
        logic        e_val;
        logic        chk_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [15:0] d, input logic rd,
                       input logic erdy, input logic [15:0] edout, input logic esop,
                       input logic eeop, input logic eval);
        vec_t t;
        t.rst = r; t.val = v; t.din = d; t.rdy = rd;
        t.e_rdy = erdy; t.e_dout = edout; t.e_sop = esop; t.e_eop = eeop; t.e_val = eval;
        t.chk_dat = eval | r;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // One full-throughput packet with dout_rdy_i held high. Checks every
    // output cycle, the header value, and that the packet sums to zero.
    task automatic run_pkt(input logic [7:0] seq_exp, input logic [15:0] base, input int pidx);
        logic [15:0] sum;
        sum = '0;
        for (int c = 0; c < 6; c++) begin
            din_val = (c < 5);
            // Cycles 0 and 1 both present word 0, because IDLE does not consume it.
            din     = (c == 0) ? base : base + 16'(c - 1);
            dout_rdy = 1'b1;
            @(posedge clk); #1;
            chk("pkt_val", pidx, 32'(dout_val), 32'd1);
            chk("pkt_sop", pidx, 32'(dout_sop), 32'(c == 0));
            chk("pkt_eop", pidx, 32'(dout_eop), 32'(c == 5));
            if (c == 0) chk("pkt_hdr", pidx, 32'(dout), 32'({seq_exp, 8'h04}));
            sum = sum + dout;
        end
        chk("pkt_sum", pidx, 32'(sum), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //    rst val din     rdy  e_rdy e_dout  sop eop val
        // Test 1: single packet 1..4 at full rate
        add(0, 1, 16'h0001, 1, 0, 16'h0004, 1, 0, 1);
        add(0, 1, 16'h0001, 1, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0002, 1, 1, 16'h0002, 0, 0, 1);
        add(0, 1, 16'h0003, 1, 1, 16'h0003, 0, 0, 1);
        add(0, 1, 16'h0004, 1, 1, 16'h0004, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 16'hFFF2, 0, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
        // Test 2: seq 1, followed immediately by seq 2 with no idle cycle
        add(0, 1, 16'h0010, 1, 0, 16'h0104, 1, 0, 1);
        add(0, 1, 16'h0010, 1, 1, 16'h0010, 0, 0, 1);
        add(0, 1, 16'h0020, 1, 1, 16'h0020, 0, 0, 1);
        add(0, 1, 16'h0030, 1, 1, 16'h0030, 0, 0, 1);
        add(0, 1, 16'h0040, 1, 1, 16'h0040, 0, 0, 1);
        add(0, 1, 16'h0100, 1, 0, 16'hFE5C, 0, 1, 1);
        add(0, 1, 16'h0100, 1, 0, 16'h0204, 1, 0, 1);
        // Test 3: backpressure for 3 cycles mid-payload, then during CSUM
        add(0, 1, 16'h0100, 1, 1, 16'h0100, 0, 0, 1);
        add(0, 1, 16'h0200, 0, 0, 16'h0100, 0, 0, 1);
        add(0, 1, 16'h0200, 0, 0, 16'h0100, 0, 0, 1);
        add(0, 1, 16'h0200, 0, 0, 16'h0100, 0, 0, 1);
        add(0, 1, 16'h0200, 1, 1, 16'h0200, 0, 0, 1);
        add(0, 1, 16'h0300, 1, 1, 16'h0300, 0, 0, 1);
        add(0, 1, 16'h0400, 1, 1, 16'h0400, 0, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 16'h0400, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 16'hF3FC, 0, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
        // Test 4: input gaps mid-packet (seq 3)
        add(0, 1, 16'h1111, 1, 0, 16'h0304, 1, 0, 1);
        add(0, 1, 16'h1111, 1, 1, 16'h1111, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 0);
        add(0, 1, 16'h2222, 1, 1, 16'h2222, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 0);
        add(0, 1, 16'h3333, 1, 1, 16'h3333, 0, 0, 1);
        add(0, 1, 16'h4444, 1, 1, 16'h4444, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h5252, 0, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
        // Test 6: reset after 2 payload words, then seq restarts at 0
        add(0, 1, 16'h0005, 1, 0, 16'h0404, 1, 0, 1);
        add(0, 1, 16'h0005, 1, 1, 16'h0005, 0, 0, 1);
        add(0, 1, 16'h0006, 1, 1, 16'h0006, 0, 0, 1);
        add(1, 1, 16'h0007, 1, 1, 16'h0000, 0, 0, 0);
        add(0, 1, 16'h0001, 1, 0, 16'h0004, 1, 0, 1);
        add(0, 1, 16'h0001, 1, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0001, 1, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0001, 1, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0001, 1, 1, 16'h0001, 0, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 16'hFFF8, 0, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);

        // Reset state
        rst = 1'b1; din = '0; din_val = 1'b0; dout_rdy = 1'b1;
        @(posedge clk); #1;
        chk("rst_dout", -1, 32'(dout), 32'd0);
        chk("rst_sop",  -1, 32'(dout_sop), 32'd0);
        chk("rst_eop",  -1, 32'(dout_eop), 32'd0);
        chk("rst_val",  -1, 32'(dout_val), 32'd0);
        chk("rst_din_rdy", -1, 32'(din_rdy), 32'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; din_val = vecs[i].val; din = vecs[i].din; dout_rdy = vecs[i].rdy;
            #1;
            chk("din_rdy", i, 32'(din_rdy), 32'(vecs[i].e_rdy));
            @(posedge clk); #1;
            chk("dout_val", i, 32'(dout_val), 32'(vecs[i].e_val));
            if (vecs[i].chk_dat) begin
                chk("dout", i, 32'(dout), 32'(vecs[i].e_dout));
                chk("dout_sop", i, 32'(dout_sop), 32'(vecs[i].e_sop));
                chk("dout_eop", i, 32'(dout_eop), 32'(vecs[i].e_eop));
            end
        end
        rst = 1'b0;

        // Test 5: seq is now 1. 256 packets run seq 1..255, then wrap to 0.
        for (int p = 0; p < 256; p++)
            run_pkt(8'(p + 1), 16'(p * 37 + 16'h0A00), p);
        chk("seq_wrap_hdr_val", 0, 32'(dout_val), 32'd1);
        din_val = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_wrap", 0, 32'(dout_val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
